uart_tx: RTL and testbench

Serial transmitter for the curated sequential circuit set. It accepts a parallel word through a valid/ready handshake and drives it onto a single idle-high line as an asynchronous serial frame: start bit, data bits LSB first, optional even parity bit, then one stop bit. Each bit is held for a fixed number of clock cycles. It is the driving end of a bit-sampling receiver chain and is built to sit directly in front of one on the same `clk`.

---
 rtl/uart_tx.sv | 153 +++++++++++++++
 tb/tb_uart_tx.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// Serial frame transmitter: start bit, LSB-first data, optional even parity, one stop bit.
// Latency: start bit appears on tx the cycle after the handshake; frame lasts (2+DATA_BITS+PARITY_EN)*CLKS_PER_BIT cycles.
// Backpressure: tx_ready is high only while idle; offers made while busy are ignored, not queued.
module uart_tx #(
   parameter int CLKS_PER_BIT = 4,
   parameter int DATA_BITS    = 8,
   parameter int PARITY_EN    = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 tx,
   output logic                 busy,
   output logic                 frame_done
);

   // Cycle counter needs at least one bit even when every bit lasts a single cycle.
   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t               r_state;
   logic [CW-1:0]        r_cnt;
   logic [BW-1:0]        r_bit;
   logic [DATA_BITS-1:0] r_shreg;
   logic                 r_par;
   logic                 r_tx;

   state_t               w_state_nxt;
   logic [CW-1:0]        w_cnt_nxt;
   logic [BW-1:0]        w_bit_nxt;
   logic [DATA_BITS-1:0] w_shreg_nxt;
   logic                 w_par_nxt;
   logic                 w_tx_nxt;
   logic                 w_last_clk;
   logic                 w_last_bit;

   assign w_last_clk = (r_cnt == LAST_CLK);
   assign w_last_bit = (r_bit == LAST_BIT);

   // Next-state and next-line logic; tx is computed one cycle ahead so the line itself is a flop.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_bit_nxt   = r_bit;
      w_shreg_nxt = r_shreg;
      w_par_nxt   = r_par;
      w_tx_nxt    = r_tx;
      case (r_state)
         S_IDLE: begin
            w_tx_nxt = 1'b1;
            if (tx_valid) begin
               w_state_nxt = S_START;
               w_shreg_nxt = tx_data;
               w_par_nxt   = (PARITY_EN != 0) ? ^tx_data : 1'b0;
               w_cnt_nxt   = '0;
               w_bit_nxt   = '0;
               w_tx_nxt    = 1'b0;
            end
         end
         S_START: begin
            if (w_last_clk) begin
               w_cnt_nxt   = '0;
               w_state_nxt = S_DATA;
               w_tx_nxt    = r_shreg[0];
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         S_DATA: begin
            if (w_last_clk) begin
               w_cnt_nxt = '0;
               if (w_last_bit) begin
                  w_bit_nxt = '0;
                  if (PARITY_EN != 0) begin
                     w_state_nxt = S_PARITY;
                     w_tx_nxt    = r_par;
                  end else begin
                     w_state_nxt = S_STOP;
                     w_tx_nxt    = 1'b1;
                  end
               end else begin
                  w_bit_nxt   = r_bit + BW'(1);
                  w_shreg_nxt = r_shreg >> 1;
                  w_tx_nxt    = r_shreg[1];
               end
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         S_PARITY: begin
            if (w_last_clk) begin
               w_cnt_nxt   = '0;
               w_state_nxt = S_STOP;
               w_tx_nxt    = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         S_STOP: begin
            w_tx_nxt = 1'b1;
            if (w_last_clk) begin
               w_cnt_nxt   = '0;
               w_state_nxt = S_IDLE;
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_bit_nxt   = '0;
            w_tx_nxt    = 1'b1;
         end
      endcase
   end

   // State, counters, shift register and line flop; reset aborts any frame in progress.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_shreg <= '0;
         r_par   <= 1'b0;
         r_tx    <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_bit   <= w_bit_nxt;
         r_shreg <= w_shreg_nxt;
         r_par   <= w_par_nxt;
         r_tx    <= w_tx_nxt;
      end
   end

   assign tx         = r_tx;
   assign tx_ready   = (r_state == S_IDLE);
   assign busy       = ~tx_ready;
   assign frame_done = (r_state == S_STOP) && w_last_clk;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (default, even parity, one-cycle bits with 5 data bits).
// Every frame is compared cycle by cycle against a frame model built from the bit layout.
// Directed corner sequences cover reset, back-to-back, ignored offers and reset mid-frame.
module tb_uart_tx;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] vld = '0;
   logic [7:0] dat0 = '0;
   logic [7:0] dat1 = '0;
   logic [4:0] dat2 = '0;
   logic [2:0] txo, rdy, bsy, fdn;

   int cpb_of [3] = '{4, 4, 1};
   int db_of  [3] = '{8, 8, 5};
   int pe_of  [3] = '{0, 1, 0};

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(0)) dut0 (
      .clk(clk), .rst(rst), .tx_data(dat0), .tx_valid(vld[0]),
      .tx_ready(rdy[0]), .tx(txo[0]), .busy(bsy[0]), .frame_done(fdn[0]));

   uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1)) dut1 (
      .clk(clk), .rst(rst), .tx_data(dat1), .tx_valid(vld[1]),
      .tx_ready(rdy[1]), .tx(txo[1]), .busy(bsy[1]), .frame_done(fdn[1]));

   uart_tx #(.CLKS_PER_BIT(1), .DATA_BITS(5), .PARITY_EN(0)) dut2 (
      .clk(clk), .rst(rst), .tx_data(dat2), .tx_valid(vld[2]),
      .tx_ready(rdy[2]), .tx(txo[2]), .busy(bsy[2]), .frame_done(fdn[2]));

   typedef struct {
      int         dut;
      logic [7:0] data;
      int         exp_len;
      logic       exp_par;
   } vec_t;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic set_in(input int d, input logic v, input logic [7:0] data);
      vld[d] = v;
      case (d)
         0: dat0 = data;
         1: dat1 = data;
         default: dat2 = data[4:0];
      endcase
   endtask

   function automatic int frame_len(input int d);
      return (2 + db_of[d] + pe_of[d]) * cpb_of[d];
   endfunction

   // Expected line level in cycle k (1-based) of a frame carrying data.
   function automatic logic model_bit(input int d, input logic [7:0] data, input int k);
      int         idx;
      logic [7:0] m;
      m   = data & (8'hFF >> (8 - db_of[d]));
      idx = (k - 1) / cpb_of[d];
      if (idx == 0) return 1'b0;
      if (idx <= db_of[d]) return m[idx-1];
      if (pe_of[d] != 0 && idx == db_of[d] + 1) return ^m;
      return 1'b1;
   endfunction

   task automatic wait_ready(input int d);
      for (int i = 0; i < 200 && rdy[d] !== 1'b1; i++) @(negedge clk);
      check($sformatf("ready_before_offer d%0d", d), 32'(rdy[d]), 32'd1);
   endtask

   // Sends one word and checks every cycle of the frame plus two idle cycles after it.
   // inj > 1 makes a spurious offer of 0x3C during cycle inj that must be ignored.
   task automatic run_frame(input int d, input logic [7:0] data, input int inj,
                            output int got_len, output logic got_par);
      int F;
      F = frame_len(d);
      got_len = -1;
      got_par = 1'bx;
      wait_ready(d);
      set_in(d, 1'b1, data);
      @(posedge clk);
      for (int k = 1; k <= F + 1; k++) begin
         @(negedge clk);
         if (k == 1) vld[d] = 1'b0;
         check($sformatf("tx d%0d data %0h k%0d", d, data, k), 32'(txo[d]), 32'(model_bit(d, data, k)));
         check($sformatf("frame_done d%0d k%0d", d, k), 32'(fdn[d]), 32'(k == F));
         check($sformatf("tx_ready d%0d k%0d", d, k), 32'(rdy[d]), 32'(k == F + 1));
         check($sformatf("busy d%0d k%0d", d, k), 32'(bsy[d]), 32'(k != F + 1));
         if (fdn[d] === 1'b1 && got_len < 0) got_len = k;
         if (pe_of[d] != 0 && k == (db_of[d] + 2) * cpb_of[d]) got_par = txo[d];
         if (inj > 1 && k == inj) set_in(d, 1'b1, 8'h3C);
         if (inj > 1 && k == inj + 1) vld[d] = 1'b0;
      end
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         check($sformatf("idle_tx_after d%0d", d), 32'(txo[d]), 32'd1);
         check($sformatf("idle_ready_after d%0d", d), 32'(rdy[d]), 32'd1);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t       vecs [7];
      int         got_len;
      logic       got_par;
      int         d;
      logic [7:0] rdata;
      int         inj;

      vecs[0] = '{0, 8'hA5, 40, 1'b0};
      vecs[1] = '{0, 8'h00, 40, 1'b0};
      vecs[2] = '{0, 8'hFF, 40, 1'b0};
      vecs[3] = '{1, 8'h07, 44, 1'b1};
      vecs[4] = '{1, 8'h03, 44, 1'b0};
      vecs[5] = '{1, 8'h80, 44, 1'b1};
      vecs[6] = '{2, 8'h15, 7,  1'b0};

      // Reset held for three cycles: all instances idle with line high.
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_tx d%0d", i), 32'(txo[i]), 32'd1);
            check($sformatf("reset_ready d%0d", i), 32'(rdy[i]), 32'd1);
            check($sformatf("reset_busy d%0d", i), 32'(bsy[i]), 32'd0);
            check($sformatf("reset_done d%0d", i), 32'(fdn[i]), 32'd0);
         end
      end
      rst = 1'b0;
      @(negedge clk);

      // Table of single frames with expected length and parity bit.
      foreach (vecs[i]) begin
         run_frame(vecs[i].dut, vecs[i].data, 0, got_len, got_par);
         check($sformatf("frame_len vec%0d", i), 32'(got_len), 32'(vecs[i].exp_len));
         if (pe_of[vecs[i].dut] != 0)
            check($sformatf("parity_bit vec%0d", i), 32'(got_par), 32'(vecs[i].exp_par));
      end

      // Back-to-back: valid held high, 0x00 then 0xFF; second handshake ends cycle 41.
      wait_ready(0);
      set_in(0, 1'b1, 8'h00);
      @(posedge clk);
      for (int k = 1; k <= 81; k++) begin
         logic e;
         @(negedge clk);
         if (k <= 40) e = model_bit(0, 8'h00, k);
         else if (k == 41) e = 1'b1;
         else e = model_bit(0, 8'hFF, k - 41);
         check($sformatf("b2b_tx k%0d", k), 32'(txo[0]), 32'(e));
         if (k == 1) dat0 = 8'hFF;
         if (k == 41) check("b2b_ready_c41", 32'(rdy[0]), 32'd1);
         if (k == 42) begin
            check("b2b_ready_c42", 32'(rdy[0]), 32'd0);
            vld[0] = 1'b0;
         end
         check($sformatf("b2b_done k%0d", k), 32'(fdn[0]), 32'(k == 40 || k == 81));
      end
      @(negedge clk);
      check("b2b_ready_c82", 32'(rdy[0]), 32'd1);
      check("b2b_tx_c82", 32'(txo[0]), 32'd1);

      // Ignored offer during a 0xA5 frame.
      run_frame(0, 8'hA5, 15, got_len, got_par);
      check("ignored_offer_len", 32'(got_len), 32'd40);

      // Reset mid-frame, then a clean 0x5A frame.
      wait_ready(0);
      set_in(0, 1'b1, 8'hA5);
      @(posedge clk);
      for (int k = 1; k < 20; k++) begin
         @(negedge clk);
         if (k == 1) vld[0] = 1'b0;
         check($sformatf("prerst_tx k%0d", k), 32'(txo[0]), 32'(model_bit(0, 8'hA5, k)));
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_tx", 32'(txo[0]), 32'd1);
      check("midrst_ready", 32'(rdy[0]), 32'd1);
      check("midrst_busy", 32'(bsy[0]), 32'd0);
      check("midrst_done", 32'(fdn[0]), 32'd0);
      @(negedge clk);
      @(negedge clk);
      check("midrst_hold_tx", 32'(txo[0]), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("postrst_tx", 32'(txo[0]), 32'd1);
         check("postrst_ready", 32'(rdy[0]), 32'd1);
      end
      run_frame(0, 8'h5A, 0, got_len, got_par);
      check("postrst_len", 32'(got_len), 32'd40);

      // Randomized frames across all instances, with occasional ignored offers.
      for (int n = 0; n < 30; n++) begin
         d     = int'($urandom_range(0, 2));
         rdata = 8'($urandom);
         inj   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, frame_len(d) - 1)) : 0;
         repeat ($urandom_range(0, 3)) @(negedge clk);
         run_frame(d, rdata, inj, got_len, got_par);
         check($sformatf("rand_len n%0d", n), 32'(got_len), 32'(frame_len(d)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
